// File: rtl/npc_pkg.sv
// npc_pkg: shared fetch-unit state encoding, NOP word and fault cause codes
package npc_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} ifu_state_t;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_BUSERR = 2'd2;
endpackage

// File: rtl/ifu_reuse_buf.sv
// ifu_reuse_buf: one-entry tag/data buffer with address compare for refetch reuse
module ifu_reuse_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] data
);
  logic                  tag_valid;
  logic [ADDR_WIDTH-1:0] tag_addr;
  always_ff @(posedge clk) begin
    if (rst || clr) tag_valid <= 1'b0;
    else if (load) begin
      tag_valid <= 1'b1;
      tag_addr  <= load_addr;
      data      <= load_data;
    end
  end
  assign hit = tag_valid && lookup_addr == tag_addr;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetches the word at pc over a valid/ready bus and holds it until consumed.
// Define IFU_REUSE_EN to add a one-entry buffer that skips the bus when pc repeats.
module inst_fetch_unit import npc_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = npc_pkg::NOP_INST,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  global_rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  core_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  inst_fault,
  output logic [1:0]            fault_cause,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_err,
  output logic [CNT_WIDTH-1:0]  fetch_count
);
  ifu_state_t              state;
  logic [ADDR_WIDTH-1:2]   addr_q;
  logic                    drop;
  logic                    reuse_hit;
  logic [DATA_WIDTH-1:0]   reuse_data;
  assign mem_req_addr = {addr_q, 2'b00};
`ifdef IFU_REUSE_EN
  logic rsp_seen;
  assign rsp_seen = state == WAIT && mem_rsp_valid;
  ifu_reuse_buf #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_reuse (
    .clk(clk),
    .rst(global_rst),
    .clr(flush || (rsp_seen && mem_rsp_err)),
    .load(rsp_seen && !mem_rsp_err && !drop),
    .load_addr(mem_req_addr),
    .load_data(mem_rsp_data),
    .lookup_addr(pc),
    .hit(reuse_hit),
    .data(reuse_data)
  );
`else
  assign reuse_hit = 1'b0;
  assign reuse_data = NOP_INST;
`endif
  always_ff @(posedge clk) begin
    if (global_rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      inst          <= NOP_INST;
      inst_valid    <= 1'b0;
      inst_fault    <= 1'b0;
      fault_cause   <= FC_NONE;
      mem_req_valid <= 1'b0;
      drop          <= 1'b0;
      fetch_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          addr_q <= pc[ADDR_WIDTH-1:2];
          if (!flush) begin
            if (pc[1:0] != 2'b00) begin
              state       <= HOLD;
              inst_valid  <= 1'b1;
              inst_fault  <= 1'b1;
              fault_cause <= FC_MISALIGN;
            end else if (reuse_hit) begin
              state      <= HOLD;
              inst_valid <= 1'b1;
              inst       <= reuse_data;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          // a flushed request still completes its handshake; only the response is dropped
          drop <= drop || flush;
          if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            fetch_count <= fetch_count + CNT_WIDTH'(1);
            drop        <= 1'b0;
            if (drop || flush) state <= IDLE;
            else begin
              state       <= HOLD;
              inst_valid  <= 1'b1;
              inst        <= mem_rsp_err ? NOP_INST : mem_rsp_data;
              inst_fault  <= mem_rsp_err;
              fault_cause <= mem_rsp_err ? FC_BUSERR : FC_NONE;
            end
          end else drop <= drop || flush;
        end
        HOLD: begin
          if (flush || core_ready) begin
            state       <= IDLE;
            inst_valid  <= 1'b0;
            inst_fault  <= 1'b0;
            fault_cause <= FC_NONE;
            inst        <= NOP_INST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
